debounce_bank: RTL and testbench

Parametrised multi-channel button front end for the LED game. It replaces the single-button press detector with N independent channels. Each channel synchronises its raw pin, debounces it with a programmable stability window, and emits press/release pulses, a debounced level, a long-press pulse and optional auto-repeat. It sits between the board pins and game logic such as LED toggling; its `pressed` pulses drive `toggle` inputs directly.

---
 rtl/ledgame_pkg.sv | 25 ++
 rtl/debounce_channel.sv | 134 +++++++++++++
 rtl/debounce_bank.sv | 49 ++++
 tb/tb_debounce_bank.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledgame_pkg.sv
// Shared definitions for the LED game front end: counter width helper,
// default timing constants and the per-channel status bundle.
package ledgame_pkg;

    // Default stability window, long-press hold time and auto-repeat period.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_HOLD_CYCLES     = 1024;
    localparam int DEFAULT_REPEAT_CYCLES   = 256;

    // Width needed to hold the value 0..value, never narrower than one bit.
    function automatic int cnt_width(input int value);
        int w;
        w = $clog2(value + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Everything one channel reports to the game logic.
    typedef struct packed {
        logic pressed;
        logic released;
        logic held;
        logic long_press;
    } chan_out_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability-window debounce,
// press/release edge pulses, long-press detection and auto-repeat.
// The input is already polarity-corrected (1 = pressed).
module debounce_channel
    import ledgame_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      button,
    input  logic      repeat_en,
    output chan_out_t status
);

    localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int REP_W  = cnt_width(REPEAT_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic              r_s0;
    logic              r_s1;
    logic              r_stable;
    logic [DB_W-1:0]   r_db_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [REP_W-1:0]  r_rep_cnt;
    logic              r_pressed;
    logic              r_released;
    logic              r_long;

    logic w_mismatch;
    logic w_flip;
    logic w_rise;
    logic w_fall;
    logic w_hold_done;
    logic w_holding;
    logic w_hold_fire;
    logic w_rep_fire;

    // A flip is accepted when the mismatch survives the last window cycle.
    // Auto-repeat and long-press only advance on cycles without a flip,
    // so pressed and released can never coincide.
    always_comb begin
        w_mismatch  = (r_s1 != r_stable);
        w_flip      = w_mismatch && (r_db_cnt == DB_LAST);
        w_rise      = w_flip && !r_stable;
        w_fall      = w_flip && r_stable;
        w_hold_done = (r_hold_cnt == HOLD_MAX);
        w_holding   = r_stable && !w_flip;
        w_hold_fire = w_holding && (r_hold_cnt == HOLD_LAST);
        w_rep_fire  = w_holding && w_hold_done && repeat_en && (r_rep_cnt == REP_LAST);
    end

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else begin
            r_s0 <= button;
            r_s1 <= r_s0;
        end
    end

    // Debounce counter and accepted (stable) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_cnt <= '0;
            r_stable <= 1'b0;
        end else begin
            if (!w_mismatch || w_flip) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
            if (w_flip) begin
                r_stable <= ~r_stable;
            end
        end
    end

    // Hold counter: counts press duration, saturates once long-press fired.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (!w_holding) begin
            r_hold_cnt <= '0;
        end else if (!w_hold_done) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end

    // Repeat counter: runs only after long-press while repeat is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt <= '0;
        end else if (!w_holding || !w_hold_done || !repeat_en) begin
            r_rep_cnt <= '0;
        end else if (r_rep_cnt == REP_LAST) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + REP_W'(1);
        end
    end

    // Registered one-cycle event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_pressed  <= w_rise || w_rep_fire;
            r_released <= w_fall;
            r_long     <= w_hold_fire;
        end
    end

    // Pack the channel status for the bank.
    always_comb begin
        status            = '0;
        status.pressed    = r_pressed;
        status.released   = r_released;
        status.held       = r_stable;
        status.long_press = r_long;
    end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel button front end: applies pin polarity and replicates
// one independent debounce channel per button.
module debounce_bank
    import ledgame_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] button,
    input  logic                repeat_en,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] held,
    output logic [CHANNELS-1:0] long_press
);

    logic [CHANNELS-1:0] w_button_fixed;
    chan_out_t           w_status [CHANNELS];

    // One channel per pin; inversion makes "pressed" read as 1 internally.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign w_button_fixed[gi] = ACTIVE_LOW ? ~button[gi] : button[gi];

            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .HOLD_CYCLES     (HOLD_CYCLES),
                .REPEAT_CYCLES   (REPEAT_CYCLES)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .button    (w_button_fixed[gi]),
                .repeat_en (repeat_en),
                .status    (w_status[gi])
            );

            assign pressed[gi]    = w_status[gi].pressed;
            assign released[gi]   = w_status[gi].released;
            assign held[gi]       = w_status[gi].held;
            assign long_press[gi] = w_status[gi].long_press;
        end
    endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: a behavioural model predicts the
// outputs after every clock edge, a monitor compares them, and directed
// scenarios also check pulse counts derived from the timing rules.
module tb_debounce_bank;

    localparam int CH   = 2;
    localparam int DB   = 4;
    localparam int HOLD = 16;
    localparam int REP  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] button;
    logic          repeat_en;
    logic [CH-1:0] pressed;
    logic [CH-1:0] released;
    logic [CH-1:0] held;
    logic [CH-1:0] long_press;

    always #5 clk = ~clk;

    debounce_bank #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP),
        .ACTIVE_LOW      (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .repeat_en  (repeat_en),
        .pressed    (pressed),
        .released   (released),
        .held       (held),
        .long_press (long_press)
    );

    typedef struct {
        logic [CH-1:0] p;
        logic [CH-1:0] r;
        logic [CH-1:0] h;
        logic [CH-1:0] l;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   fail_prints = 0;
    int   cycle       = 0;

    // Behavioural model state: pin sample history, accepted level, length
    // of the current disagreement run, time since press, time since last
    // long-press/repeat event.
    bit m_samp_new [CH];
    bit m_samp_old [CH];
    bit m_stable   [CH];
    int m_run      [CH];
    int m_age      [CH];
    int m_rep      [CH];

    // Model: one expected output vector per clock edge.
    initial begin
        exp_t e;
        bit   synced;
        bit   flipped;
        for (int c = 0; c < CH; c++) begin
            m_samp_new[c] = 0; m_samp_old[c] = 0; m_stable[c] = 0;
            m_run[c] = 0; m_age[c] = 0; m_rep[c] = 0;
        end
        forever begin
            @(posedge clk);
            e.p = '0; e.r = '0; e.h = '0; e.l = '0;
            for (int c = 0; c < CH; c++) begin
                if (rst) begin
                    m_samp_new[c] = 0; m_samp_old[c] = 0; m_stable[c] = 0;
                    m_run[c] = 0; m_age[c] = 0; m_rep[c] = 0;
                end else begin
                    // level seen by the debouncer is the pin from two edges ago
                    synced        = m_samp_old[c];
                    m_samp_old[c] = m_samp_new[c];
                    m_samp_new[c] = button[c];
                    flipped       = 0;
                    if (synced != m_stable[c]) begin
                        m_run[c]++;
                        if (m_run[c] == DB) begin
                            m_stable[c] = synced;
                            m_run[c]    = 0;
                            flipped     = 1;
                            m_age[c]    = 0;
                            m_rep[c]    = 0;
                            if (synced) e.p[c] = 1'b1;
                            else        e.r[c] = 1'b1;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                    if (m_stable[c] && !flipped) begin
                        if (m_age[c] <= HOLD) m_age[c]++;
                        if (m_age[c] == HOLD) begin
                            e.l[c] = 1'b1;
                        end else if (m_age[c] > HOLD) begin
                            if (repeat_en) begin
                                m_rep[c]++;
                                if (m_rep[c] == REP) begin
                                    e.p[c]   = 1'b1;
                                    m_rep[c] = 0;
                                end
                            end else begin
                                m_rep[c] = 0;
                            end
                        end
                    end
                end
                e.h[c] = m_stable[c];
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compare DUT outputs against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty cycle %0d: got no prediction, want one per edge", cycle);
            end else begin
                e = exp_q.pop_front();
                if (pressed !== e.p || released !== e.r || held !== e.h || long_press !== e.l) begin
                    miscompares++;
                    if (fail_prints < 40) begin
                        fail_prints++;
                        $display("FAIL outputs cycle %0d: got p=%b r=%b h=%b l=%b want p=%b r=%b h=%b l=%b",
                                 cycle, pressed, released, held, long_press, e.p, e.r, e.h, e.l);
                    end
                end
            end
        end
    end

    // Pulse counters used by the directed scenario checks.
    int cnt_p [CH];
    int cnt_r [CH];
    int cnt_l [CH];
    int cnt_h [CH];
    int cnt_both = 0;

    initial begin
        for (int c = 0; c < CH; c++) begin
            cnt_p[c] = 0; cnt_r[c] = 0; cnt_l[c] = 0; cnt_h[c] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < CH; c++) begin
                cnt_p[c] += int'(pressed[c]);
                cnt_r[c] += int'(released[c]);
                cnt_l[c] += int'(long_press[c]);
                cnt_h[c] += int'(held[c]);
            end
            if (pressed == {CH{1'b1}}) cnt_both++;
        end
    end

    int b_p [CH];
    int b_r [CH];
    int b_l [CH];
    int b_h [CH];
    int b_both;

    task automatic snap();
        b_p = cnt_p; b_r = cnt_r; b_l = cnt_l; b_h = cnt_h; b_both = cnt_both;
    endtask

    task automatic check_count(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d pulses/cycles, want %0d", name, got, want);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        int cd [CH];
        rst       = 1'b1;
        button    = '0;
        repeat_en = 1'b0;
        ticks(3);
        rst = 1'b0;
        ticks(5);

        // Clean press, held 30 cycles, no repeat.
        snap();
        button[0] = 1'b1;
        ticks(30);
        button[0] = 1'b0;
        ticks(12);
        check_count("clean_pressed",  cnt_p[0] - b_p[0], 1);
        check_count("clean_long",     cnt_l[0] - b_l[0], 1);
        check_count("clean_released", cnt_r[0] - b_r[0], 1);
        check_count("clean_held_cycles", cnt_h[0] - b_h[0], 30);
        $display("scenario clean_press done at cycle %0d", cycle);

        // Bounce: 2-cycle toggles, last transition to high.
        snap();
        for (int k = 0; k < 6; k++) begin
            button[0] = (k % 2 == 1);
            ticks(2);
        end
        ticks(18);
        check_count("bounce_pressed",  cnt_p[0] - b_p[0], 1);
        check_count("bounce_released", cnt_r[0] - b_r[0], 0);
        button[0] = 1'b0;
        ticks(12);
        $display("scenario bounce done at cycle %0d", cycle);

        // Glitch: 3-cycle pulse on ch1.
        snap();
        button[1] = 1'b1;
        ticks(3);
        button[1] = 1'b0;
        ticks(12);
        check_count("glitch_pressed",  cnt_p[1] - b_p[1], 0);
        check_count("glitch_released", cnt_r[1] - b_r[1], 0);
        check_count("glitch_held",     cnt_h[1] - b_h[1], 0);
        $display("scenario glitch done at cycle %0d", cycle);

        // Auto-repeat with enable dropped at edge 40.
        snap();
        button[0] = 1'b1;
        repeat_en = 1'b1;
        ticks(40);
        repeat_en = 1'b0;
        ticks(10);
        button[0] = 1'b0;
        ticks(12);
        check_count("repeat_pressed", cnt_p[0] - b_p[0], 3);
        check_count("repeat_long",    cnt_l[0] - b_l[0], 1);
        $display("scenario auto_repeat done at cycle %0d", cycle);

        // Reset in the middle of a press.
        snap();
        button[0] = 1'b1;
        ticks(10);
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(10);
        check_count("reset_pressed",  cnt_p[0] - b_p[0], 2);
        check_count("reset_released", cnt_r[0] - b_r[0], 0);
        button[0] = 1'b0;
        ticks(12);
        $display("scenario reset_mid_press done at cycle %0d", cycle);

        // Independence: both pressed together, ch1 released early.
        snap();
        button = 2'b11;
        ticks(10);
        button[1] = 1'b0;
        ticks(20);
        button[0] = 1'b0;
        ticks(12);
        check_count("indep_same_cycle", cnt_both - b_both, 1);
        check_count("indep_long_ch0",   cnt_l[0] - b_l[0], 1);
        check_count("indep_long_ch1",   cnt_l[1] - b_l[1], 0);
        check_count("indep_rel_ch1",    cnt_r[1] - b_r[1], 1);
        $display("scenario independence done at cycle %0d", cycle);

        // Randomized traffic: mix of short bounces and long holds.
        for (int c = 0; c < CH; c++) cd[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (cd[c] == 0) begin
                    button[c] = ~button[c];
                    cd[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                       : int'($urandom_range(1, 8));
                end else begin
                    cd[c]--;
                end
            end
            if ($urandom_range(0, 63) == 0) repeat_en = ~repeat_en;
            rst = ($urandom_range(0, 399) == 0);
            ticks(1);
        end
        rst = 1'b0;
        ticks(4);
        $display("scenario random done at cycle %0d", cycle);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
